// File: rtl/pc_stack_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_seq_if
// Brief    : Command / status bundle between the control unit and the
//            program-counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_stack_seq_if #(
    parameter int ADDR_W      = 5,
    parameter int OFFS_W      = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    // Command strobes and operands (control unit -> sequencer)
    logic                stall;
    logic                inc;
    logic                jmp;
    logic                br;
    logic                call;
    logic                ret;
    logic                clr_flags;
    logic [ADDR_W-1:0]   target;
    logic [OFFS_W-1:0]   offset;

    // Status (sequencer -> control unit / instruction memory)
    logic [ADDR_W-1:0]   pc;
    logic                ovf;
    logic                stack_err;
    logic                stack_empty;
    logic                stack_full;
    logic [DEPTH_W-1:0]  depth;

    modport master (
        output stall, inc, jmp, br, call, ret, clr_flags, target, offset,
        input  pc, ovf, stack_err, stack_empty, stack_full, depth
    );

    modport slave (
        input  stall, inc, jmp, br, call, ret, clr_flags, target, offset,
        output pc, ovf, stack_err, stack_empty, stack_full, depth
    );
endinterface
`default_nettype wire

// File: rtl/pc_stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_seq
// Brief    : Program-counter sequencer with increment, absolute jump, signed
//            relative branch and call/return through a return-address stack.
//            Wrap or saturate on PC overflow; sticky overflow / stack-error.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_seq #(
    parameter int ADDR_W      = 5,
    parameter int OFFS_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SATURATE    = 0
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    pc_stack_seq_if.slave      bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    // Two guard bits: one for sign, one so PC+offset never aliases past MAX.
    localparam int SUM_W   = ADDR_W + 2;

    localparam logic [ADDR_W-1:0]  c_PC_MAX     = '1;
    localparam logic [DEPTH_W-1:0] c_DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic               ovf_q,   ovf_d;
    logic               err_q,   err_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic               w_push;
    logic               w_empty;
    logic               w_full;
    logic [ADDR_W-1:0]  w_top;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [SUM_W-1:0]   w_br_sum;
    logic               w_br_neg;
    logic               w_br_high;

    assign w_empty   = (depth_q == '0);
    assign w_full    = (depth_q == c_DEPTH_FULL);
    assign w_pc_inc  = pc_q + ADDR_W'(1);
    assign w_br_sum  = {{(SUM_W-OFFS_W){bus.offset[OFFS_W-1]}}, bus.offset}
                     + {2'b00, pc_q};
    assign w_br_neg  = w_br_sum[SUM_W-1];
    assign w_br_high = !w_br_neg && w_br_sum[ADDR_W];

    // Select the entry at depth-1 as the return address.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                w_top = stack_q[i];
            end
        end
    end

    // Next-state decode: one command acts per cycle, ret > call > jmp > br > inc.
    always_comb begin
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        depth_d = depth_q;
        w_push  = 1'b0;
        if (!bus.stall) begin
            // Clearing first lets a same-cycle error set the flag again.
            if (bus.clr_flags) begin
                ovf_d = 1'b0;
                err_d = 1'b0;
            end
            if (bus.ret) begin
                if (w_empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d    = w_top;
                    depth_d = depth_q - DEPTH_W'(1);
                end
            end else if (bus.call) begin
                if (w_full) begin
                    err_d = 1'b1;
                end else begin
                    w_push  = 1'b1;
                    pc_d    = bus.target;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end else if (bus.jmp) begin
                pc_d = bus.target;
            end else if (bus.br) begin
                if (w_br_neg) begin
                    ovf_d = 1'b1;
                    pc_d  = (SATURATE != 0) ? '0 : w_br_sum[ADDR_W-1:0];
                end else if (w_br_high) begin
                    ovf_d = 1'b1;
                    pc_d  = (SATURATE != 0) ? c_PC_MAX : w_br_sum[ADDR_W-1:0];
                end else begin
                    pc_d  = w_br_sum[ADDR_W-1:0];
                end
            end else if (bus.inc) begin
                if (pc_q == c_PC_MAX) begin
                    ovf_d = 1'b1;
                    pc_d  = (SATURATE != 0) ? c_PC_MAX : '0;
                end else begin
                    pc_d  = w_pc_inc;
                end
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push && (depth_q == DEPTH_W'(i))) begin
                stack_q[i] <= w_pc_inc;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ovf         = ovf_q;
    assign bus.stack_err   = err_q;
    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.depth       = depth_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_stack_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_seq
// Brief    : Self-checking bench; a wrapping and a saturating instance run
//            in lockstep against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_seq;
    localparam int AW   = 5;
    localparam int OW   = 4;
    localparam int SD   = 4;
    localparam int DW   = $clog2(SD + 1);
    localparam int VW   = AW + 4 + DW;
    localparam int MAXV = (1 << AW) - 1;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    // Behavioural model: index 0 = wrapping instance, 1 = saturating instance
    int m_pc  [2];
    int m_dep [2];
    bit m_ovf [2];
    bit m_err [2];
    int m_stk [2][SD];

    pc_stack_seq_if #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD)) bus0 ();
    pc_stack_seq_if #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD)) bus1 ();

    pc_stack_seq #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD), .SATURATE(0))
        u_dut_wrap (.clk(clk), .rstn(rstn), .bus(bus0));
    pc_stack_seq #(.ADDR_W(AW), .OFFS_W(OW), .STACK_DEPTH(SD), .SATURATE(1))
        u_dut_sat  (.clk(clk), .rstn(rstn), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] expv(input int k);
        return {AW'(m_pc[k]), m_ovf[k], m_err[k], m_dep[k] == 0, m_dep[k] == SD, DW'(m_dep[k])};
    endfunction

    function automatic logic [VW-1:0] obsv(input int k);
        if (k == 0)
            return {bus0.pc, bus0.ovf, bus0.stack_err, bus0.stack_empty, bus0.stack_full, bus0.depth};
        return {bus1.pc, bus1.ovf, bus1.stack_err, bus1.stack_empty, bus1.stack_full, bus1.depth};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_dep[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
        end
    endtask

    // Arithmetic result outside 0..MAX either wraps or clamps, and flags ovf.
    task automatic model_arith(input int k, input int s);
        if (s > MAXV || s < 0) begin
            m_ovf[k] = 1;
            if (k == 1) m_pc[k] = (s > MAXV) ? MAXV : 0;
            else        m_pc[k] = ((s % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
        end else begin
            m_pc[k] = s;
        end
    endtask

    task automatic model_step(input int k, input logic st, i, j, b, c, r, clr,
                              input logic [AW-1:0] tgt, input logic [OW-1:0] off);
        int soff;
        if (st) return;
        soff = int'(off);
        if (soff >= (1 << (OW - 1))) soff -= (1 << OW);
        if (clr) begin m_ovf[k] = 0; m_err[k] = 0; end
        if (r) begin
            if (m_dep[k] == 0) m_err[k] = 1;
            else begin m_dep[k]--; m_pc[k] = m_stk[k][m_dep[k]]; end
        end else if (c) begin
            if (m_dep[k] == SD) m_err[k] = 1;
            else begin
                m_stk[k][m_dep[k]] = (m_pc[k] + 1) % (MAXV + 1);
                m_dep[k]++;
                m_pc[k] = int'(tgt);
            end
        end else if (j) begin
            m_pc[k] = int'(tgt);
        end else if (b) begin
            model_arith(k, m_pc[k] + soff);
        end else if (i) begin
            model_arith(k, m_pc[k] + 1);
        end
    endtask

    task automatic set_in(input logic st, i, j, b, c, r, clr,
                          input logic [AW-1:0] tgt, input logic [OW-1:0] off);
        bus0.stall = st; bus0.inc = i; bus0.jmp = j; bus0.br = b; bus0.call = c;
        bus0.ret = r; bus0.clr_flags = clr; bus0.target = tgt; bus0.offset = off;
        bus1.stall = st; bus1.inc = i; bus1.jmp = j; bus1.br = b; bus1.call = c;
        bus1.ret = r; bus1.clr_flags = clr; bus1.target = tgt; bus1.offset = off;
    endtask

    // Apply one cycle of command to both instances and the model.
    task automatic step(input logic st, i, j, b, c, r, clr,
                        input logic [AW-1:0] tgt, input logic [OW-1:0] off);
        set_in(st, i, j, b, c, r, clr, tgt, off);
        @(posedge clk);
        model_step(0, st, i, j, b, c, r, clr, tgt, off);
        model_step(1, st, i, j, b, c, r, clr, tgt, off);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, '0, '0);
        #2 rstn = 1'b0;
        model_reset();
        #10;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL reset dut%0d got %h exp %h", k, obsv(k), {5'd0, 4'b0010, 3'd0});
            end
        end
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_inc_wrap();
        do_reset();
        repeat (MAXV) step(0, 1, 0, 0, 0, 0, 0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== expv(k) || obsv(k) !== {5'd31, 4'b0010, 3'd0}) begin
                errors++;
                $display("FAIL inc_to_max dut%0d got %h exp %h", k, obsv(k), {5'd31, 4'b0010, 3'd0});
            end
        end
        step(0, 1, 0, 0, 0, 0, 0, '0, '0);
        checks++;
        if (bus0.pc !== 5'd0 || bus0.ovf !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap got pc=%0d ovf=%b exp pc=0 ovf=1", bus0.pc, bus0.ovf);
        end
        checks++;
        if (bus1.pc !== 5'd31 || bus1.ovf !== 1'b1) begin
            errors++;
            $display("FAIL inc_sat got pc=%0d ovf=%b exp pc=31 ovf=1", bus1.pc, bus1.ovf);
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0, 5'd10, '0);
        step(0, 0, 0, 1, 0, 0, 0, '0, 4'd5);
        checks++;
        if (bus0.pc !== 5'd15 || bus1.pc !== 5'd15) begin
            errors++;
            $display("FAIL br_plus5 got %0d/%0d exp 15", bus0.pc, bus1.pc);
        end
        step(0, 0, 0, 1, 0, 0, 0, '0, 4'b1101);
        checks++;
        if (bus0.pc !== 5'd12 || bus1.pc !== 5'd12) begin
            errors++;
            $display("FAIL br_minus3 got %0d/%0d exp 12", bus0.pc, bus1.pc);
        end
        step(0, 0, 1, 0, 0, 0, 0, 5'd31, '0);
        checks++;
        if (bus0.pc !== 5'd31 || bus0.ovf !== 1'b0 || bus1.pc !== 5'd31 || bus1.ovf !== 1'b0) begin
            errors++;
            $display("FAIL jmp_max got %0d/%b exp 31/0", bus0.pc, bus0.ovf);
        end
        step(0, 0, 1, 0, 0, 0, 1, 5'd3, '0);
        step(0, 0, 0, 1, 0, 0, 0, '0, 4'b1000);
        checks++;
        if (bus0.pc !== 5'd27 || bus0.ovf !== 1'b1) begin
            errors++;
            $display("FAIL br_under_wrap got pc=%0d ovf=%b exp 27/1", bus0.pc, bus0.ovf);
        end
        checks++;
        if (bus1.pc !== 5'd0 || bus1.ovf !== 1'b1) begin
            errors++;
            $display("FAIL br_under_sat got pc=%0d ovf=%b exp 0/1", bus1.pc, bus1.ovf);
        end
        step(0, 0, 0, 0, 0, 0, 1, '0, '0);
        step(0, 0, 0, 1, 0, 0, 0, '0, 4'd0);
        step(0, 0, 1, 0, 0, 0, 0, 5'd30, '0);
        step(0, 0, 0, 1, 0, 0, 0, '0, 4'd7);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== expv(k)) begin
                errors++;
                $display("FAIL br_over dut%0d got %h exp %h", k, obsv(k), expv(k));
            end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0, 5'd4, '0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd20, '0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd8, '0);
        checks++;
        if (bus0.pc !== 5'd8 || bus0.depth !== 3'd2 || bus1.pc !== 5'd8) begin
            errors++;
            $display("FAIL call2 got pc=%0d depth=%0d exp 8/2", bus0.pc, bus0.depth);
        end
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (bus0.pc !== 5'd21 || bus1.pc !== 5'd21) begin
            errors++;
            $display("FAIL ret1 got %0d/%0d exp 21", bus0.pc, bus1.pc);
        end
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (bus0.pc !== 5'd5 || bus0.stack_empty !== 1'b1 || bus1.pc !== 5'd5) begin
            errors++;
            $display("FAIL ret2 got pc=%0d empty=%b exp 5/1", bus0.pc, bus0.stack_empty);
        end
        step(0, 0, 1, 0, 0, 0, 0, 5'd31, '0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd2, '0);
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (bus0.pc !== 5'd0 || bus0.ovf !== 1'b0 || bus1.pc !== 5'd0 || bus1.ovf !== 1'b0) begin
            errors++;
            $display("FAIL call_at_max got pc=%0d ovf=%b exp 0/0", bus0.pc, bus0.ovf);
        end
    endtask

    task automatic test_stack_err();
        do_reset();
        for (int n = 1; n <= SD; n++) step(0, 0, 0, 0, 1, 0, 0, AW'(n), '0);
        checks++;
        if (bus0.stack_full !== 1'b1 || bus0.depth !== 3'd4 || bus0.pc !== 5'd4) begin
            errors++;
            $display("FAIL full got full=%b depth=%0d pc=%0d exp 1/4/4", bus0.stack_full, bus0.depth, bus0.pc);
        end
        step(0, 0, 0, 0, 1, 0, 0, 5'd9, '0);
        checks++;
        if (bus0.pc !== 5'd4 || bus0.stack_err !== 1'b1 || bus1.stack_err !== 1'b1) begin
            errors++;
            $display("FAIL push_full got pc=%0d err=%b exp 4/1", bus0.pc, bus0.stack_err);
        end
        step(0, 0, 0, 0, 0, 0, 1, '0, '0);
        checks++;
        if (bus0.stack_err !== 1'b0 || bus1.stack_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err got %b/%b exp 0", bus0.stack_err, bus1.stack_err);
        end
        repeat (SD) step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (bus0.pc !== 5'd1 || bus0.stack_err !== 1'b1 || bus0.stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty got pc=%0d err=%b exp 1/1", bus0.pc, bus0.stack_err);
        end
        step(0, 0, 0, 0, 0, 1, 1, '0, '0);
        checks++;
        if (bus0.stack_err !== 1'b1 || bus1.stack_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set got %b/%b exp 1", bus0.stack_err, bus1.stack_err);
        end
    endtask

    task automatic test_priority();
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0, 5'd6, '0);
        step(0, 0, 0, 0, 1, 0, 0, 5'd12, '0);
        step(0, 1, 1, 0, 0, 1, 0, 5'd25, '0);
        checks++;
        if (bus0.pc !== 5'd7 || bus0.depth !== 3'd0) begin
            errors++;
            $display("FAIL ret_wins got pc=%0d depth=%0d exp 7/0", bus0.pc, bus0.depth);
        end
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        step(1, 0, 0, 0, 1, 0, 1, 5'd3, '0);
        checks++;
        if (bus0.pc !== 5'd7 || bus0.stack_err !== 1'b1 || bus0.depth !== 3'd0) begin
            errors++;
            $display("FAIL stall got pc=%0d err=%b depth=%0d exp 7/1/0", bus0.pc, bus0.stack_err, bus0.depth);
        end
        step(0, 1, 1, 1, 1, 0, 0, 5'd17, 4'd5);
        step(0, 1, 1, 1, 0, 0, 0, 5'd9, 4'd5);
        step(0, 1, 0, 1, 0, 0, 0, '0, 4'd2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== expv(k)) begin
                errors++;
                $display("FAIL prio_chain dut%0d got %h exp %h", k, obsv(k), expv(k));
            end
        end
        step(0, 1, 0, 0, 0, 0, 0, '0, '0);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== {5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL mid_reset dut%0d got %h exp %h", k, obsv(k), {5'd0, 4'b0010, 3'd0});
            end
        end
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_random();
        logic st, i, j, b, c, r, clr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            st  = ($urandom_range(99, 0) < 10);
            i   = ($urandom_range(99, 0) < 40);
            j   = ($urandom_range(99, 0) < 15);
            b   = ($urandom_range(99, 0) < 30);
            c   = ($urandom_range(99, 0) < 20);
            r   = ($urandom_range(99, 0) < 20);
            clr = ($urandom_range(99, 0) < 8);
            step(st, i, j, b, c, r, clr, AW'($urandom), OW'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsv(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random n=%0d dut%0d got %h exp %h", n, k, obsv(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_inc_wrap();
        test_branch();
        test_call_ret();
        test_stack_err();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
